// File: rtl/fetch_unit_if.sv
// Instruction-bus and decode-handshake signals of the fetch unit.
// The master side is the fetch unit. The slave side is the memory and decode.
interface fetch_unit_if;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        fetch_err_o;

    modport master (
        output mem_rd_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, fetch_err_o,
        input  mem_data_i, mem_ack_i, instr_ready_i
    );

    modport slave (
        input  mem_rd_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, fetch_err_o,
        output mem_data_i, mem_ack_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch unit. It has at most one outstanding bus read.
// It drives the PC load pair and presents fetched words to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] ERR_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc_i,
    output logic               pc_load_o,
    output logic [31:0]        pc_next_o,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_addr_i,
    fetch_unit_if.master       bus
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      r_state,       w_state_nxt;
    logic        r_pc_load,     w_pc_load_nxt;
    logic [31:0] r_pc_next,     w_pc_next_nxt;
    logic        r_mem_rd,      w_mem_rd_nxt;
    logic [31:0] r_mem_addr,    w_mem_addr_nxt;
    logic        r_instr_valid, w_instr_valid_nxt;
    logic [31:0] r_instr,       w_instr_nxt;
    logic [31:0] r_instr_pc,    w_instr_pc_nxt;
    logic        r_fetch_err,   w_fetch_err_nxt;

    // NOTE: the payload registers are reset as well, so every output reads 0 during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc_load     <= 1'b0;
            r_pc_next     <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_load     <= w_pc_load_nxt;
            r_pc_next     <= w_pc_next_nxt;
            r_mem_rd      <= w_mem_rd_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_fetch_err   <= w_fetch_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_load_nxt     = 1'b0;
        w_pc_next_nxt     = r_pc_next;
        w_mem_rd_nxt      = r_mem_rd;
        w_mem_addr_nxt    = r_mem_addr;
        w_instr_valid_nxt = r_instr_valid;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_fetch_err_nxt   = r_fetch_err;

        if (redirect_i) begin
            w_pc_load_nxt     = 1'b1;
            w_pc_next_nxt     = redirect_addr_i;
            w_instr_valid_nxt = 1'b0;
            w_fetch_err_nxt   = 1'b0;
            case (r_state)
                REQ, DROP: begin
                    // A pending read cannot be withdrawn, so DROP waits out its ack.
                    if (bus.mem_ack_i) begin
                        w_mem_rd_nxt = 1'b0;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_state_nxt  = DROP;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    // While a PC load is still landing, pc_i is stale, so wait one cycle.
                    if (!r_pc_load) begin
                        if (pc_i[1:0] == 2'b00) begin
                            w_mem_rd_nxt   = 1'b1;
                            w_mem_addr_nxt = pc_i;
                            w_state_nxt    = REQ;
                        end else begin
                            w_instr_valid_nxt = 1'b1;
                            w_fetch_err_nxt   = 1'b1;
                            w_instr_nxt       = ERR_INSTR;
                            w_instr_pc_nxt    = pc_i;
                            w_state_nxt       = HOLD;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack_i) begin
                        w_mem_rd_nxt      = 1'b0;
                        w_instr_nxt       = bus.mem_data_i;
                        w_instr_pc_nxt    = r_mem_addr;
                        w_instr_valid_nxt = 1'b1;
                        w_fetch_err_nxt   = 1'b0;
                        w_pc_load_nxt     = 1'b1;
                        w_pc_next_nxt     = r_mem_addr + 32'd4;
                        w_state_nxt       = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instr_ready_i) begin
                        w_instr_valid_nxt = 1'b0;
                        w_state_nxt       = IDLE;
                    end
                end
                DROP: begin
                    if (bus.mem_ack_i) begin
                        w_mem_rd_nxt = 1'b0;
                        w_state_nxt  = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign pc_load_o         = r_pc_load;
    assign pc_next_o         = r_pc_next;
    assign bus.mem_rd_o      = r_mem_rd;
    assign bus.mem_addr_o    = r_mem_addr;
    assign bus.instr_valid_o = r_instr_valid;
    assign bus.instr_o       = r_instr;
    assign bus.instr_pc_o    = r_instr_pc;
    assign bus.fetch_err_o   = r_fetch_err;

endmodule
